// File: rtl/jtag_tap_generic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_tap_generic : IEEE 1149.1 TAP controller with IR, BYPASS and        |
// |                    optional IDCODE (enable with JTAG_TAP_IDCODE_EN).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jtag_tap_generic #(
    parameter int                 IR_BITS      = 4,
    parameter logic [IR_BITS-1:0] IR_RESET     = '1,
    parameter logic [IR_BITS-1:0] IR_IDCODE    = IR_BITS'(1),
    parameter logic [31:0]        IDCODE_VALUE = 32'h1000_0001
) (
    input  logic               tck,
    input  logic               trst_n,
    input  logic               tms,
    input  logic               pin_tdi,
    output logic               pin_tdo,
    output logic               pin_tdo_oe,
    output logic               tdi,
    input  logic               tdo,
    output logic [IR_BITS-1:0] ir,
    output logic               capture_dr,
    output logic               shift_dr,
    output logic               update_dr,
    output logic               user_sel,
    output logic               tlr
);

    typedef enum logic [3:0] {
        ST_EX2_DR = 4'h0,
        ST_EX1_DR = 4'h1,
        ST_SH_DR  = 4'h2,
        ST_PAU_DR = 4'h3,
        ST_SEL_IR = 4'h4,
        ST_UPD_DR = 4'h5,
        ST_CAP_DR = 4'h6,
        ST_SEL_DR = 4'h7,
        ST_EX2_IR = 4'h8,
        ST_EX1_IR = 4'h9,
        ST_SH_IR  = 4'hA,
        ST_PAU_IR = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPD_IR = 4'hD,
        ST_CAP_IR = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_t;

    localparam logic [IR_BITS-1:0] c_bypass     = '1;
    localparam logic [IR_BITS-1:0] c_ir_capture = IR_BITS'(1);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_BITS-1:0] c_ir_rst     = IR_IDCODE;
`else
    localparam logic [IR_BITS-1:0] c_ir_rst     = IR_RESET;
`endif

    tap_state_t         r_state;
    tap_state_t         w_next;
    logic [IR_BITS-1:0] r_ir_shift;
    logic [IR_BITS-1:0] r_ir;
    logic               r_bypass;
    logic               w_sel_bypass;
    logic               w_unused_cfg;

    // Keeps every configuration parameter referenced in both build flavours.
    assign w_unused_cfg = ^{IR_RESET, IR_IDCODE, IDCODE_VALUE};
    assign w_sel_bypass = (r_ir == c_bypass);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:    w_next = tms ? ST_TLR    : ST_RTI;
            ST_RTI:    w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_next = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_SEL_IR: w_next = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_DR: w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_next = tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: w_next = tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: w_next = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_CAP_IR: w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_next = tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: w_next = tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: w_next = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_next = tms ? ST_SEL_DR : ST_RTI;
            default:   w_next = ST_TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_shift <= '0;
        end else if (r_state == ST_CAP_IR) begin
            r_ir_shift <= c_ir_capture;
        end else if (r_state == ST_SH_IR) begin
            r_ir_shift <= {pin_tdi, r_ir_shift[IR_BITS-1:1]};
        end
    end

    // Loading on the edge that enters UPD_IR/TLR makes the new ir visible
    // for the whole cycle spent in that state.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir <= c_ir_rst;
        end else if (w_next == ST_TLR) begin
            r_ir <= c_ir_rst;
        end else if (w_next == ST_UPD_IR) begin
            r_ir <= r_ir_shift;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_CAP_DR) begin
            r_bypass <= 1'b0;
        end else if (r_state == ST_SH_DR) begin
            r_bypass <= pin_tdi;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] r_idcode;
    logic        w_sel_idcode;

    assign w_sel_idcode = (r_ir == IR_IDCODE);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_idcode <= IDCODE_VALUE;
        end else if (r_state == ST_CAP_DR) begin
            r_idcode <= IDCODE_VALUE;
        end else if (r_state == ST_SH_DR) begin
            r_idcode <= {pin_tdi, r_idcode[31:1]};
        end
    end
`endif

    always_comb begin
        pin_tdo    = 1'b0;
        pin_tdo_oe = 1'b0;
        capture_dr = (r_state == ST_CAP_DR);
        shift_dr   = (r_state == ST_SH_DR);
        update_dr  = (r_state == ST_UPD_DR);
        tlr        = (r_state == ST_TLR);
        tdi        = pin_tdi;
        ir         = r_ir;
`ifdef JTAG_TAP_IDCODE_EN
        user_sel   = !w_sel_bypass && !w_sel_idcode;
`else
        user_sel   = !w_sel_bypass;
`endif
        if (r_state == ST_SH_IR) begin
            pin_tdo    = r_ir_shift[0];
            pin_tdo_oe = 1'b1;
        end else if (r_state == ST_SH_DR) begin
            pin_tdo_oe = 1'b1;
            if (w_sel_bypass) begin
                pin_tdo = r_bypass;
`ifdef JTAG_TAP_IDCODE_EN
            end else if (w_sel_idcode) begin
                pin_tdo = r_idcode[0];
`endif
            end else begin
                pin_tdo = tdo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_generic.sv
`default_nettype none
// Testbench for jtag_tap_generic: queue-based TAP model checked every cycle,
// plus directed scans with hand-computed expectations.
module tb_jtag_tap_generic;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tms;
    logic       pin_tdi;
    logic       pin_tdo;
    logic       pin_tdo_oe;
    logic       tdi;
    logic       tdo;
    logic [3:0] ir;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       user_sel;
    logic       tlr;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef JTAG_TAP_IDCODE_EN
    localparam bit          IDC_EN = 1'b1;
    localparam logic [3:0]  C_RST  = 4'h1;
`else
    localparam bit          IDC_EN = 1'b0;
    localparam logic [3:0]  C_RST  = 4'hF;
`endif
    localparam logic [31:0] IDC    = 32'h1000_0001;

    jtag_tap_generic #(.IR_BITS(4)) dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .pin_tdi    (pin_tdi),
        .pin_tdo    (pin_tdo),
        .pin_tdo_oe (pin_tdo_oe),
        .tdi        (tdi),
        .tdo        (tdo),
        .ir         (ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .user_sel   (user_sel),
        .tlr        (tlr)
    );

    always #5 tck = ~tck;

    // 12-bit user data register looped back through tdi/tdo
    logic [11:0] ureg  = 12'h000;
    logic [11:0] uhold = 12'hA5C;
    assign tdo = ureg[0];
    always @(posedge tck) begin
        if (user_sel) begin
            if (capture_dr)     ureg  <= uhold;
            else if (shift_dr)  ureg  <= {tdi, ureg[11:1]};
            else if (update_dr) uhold <= ureg;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6,
                   E2DR = 7, UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12,
                   PIR = 13, E2IR = 14, UIR = 15;
    int nxt0 [16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
    int nxt1 [16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

    int          m_state = TLR;
    logic [3:0]  m_ir    = C_RST;
    bit          irq[$]  = '{0, 0, 0, 0};
    bit          drq[$];
    logic [11:0] m_uhold = 12'hA5C;

    function automatic bit m_is_idcode(input logic [3:0] v);
        return IDC_EN && (v == 4'h1);
    endfunction

    function automatic bit m_is_user(input logic [3:0] v);
        return (v != 4'hF) && !m_is_idcode(v);
    endfunction

    always @(posedge tck or negedge trst_n) begin
        int nx;
        if (!trst_n) begin
            m_state = TLR;
            m_ir    = C_RST;
            irq     = '{0, 0, 0, 0};
        end else begin
            case (m_state)
                CIR:  irq = '{1, 0, 0, 0};
                SHIR: begin void'(irq.pop_front()); irq.push_back(pin_tdi); end
                CDR: begin
                    drq.delete();
                    if (m_ir == 4'hF) drq.push_back(1'b0);
                    else if (m_is_idcode(m_ir)) for (int k = 0; k < 32; k++) drq.push_back(IDC[k]);
                    else for (int k = 0; k < 12; k++) drq.push_back(m_uhold[k]);
                end
                SHDR: begin void'(drq.pop_front()); drq.push_back(pin_tdi); end
                UDR: if (m_is_user(m_ir)) for (int k = 0; k < 12; k++) m_uhold[k] = drq[k];
                default: ;
            endcase
            nx = tms ? nxt1[m_state] : nxt0[m_state];
            if (nx == TLR) m_ir = C_RST;
            else if (nx == UIR) for (int k = 0; k < 4; k++) m_ir[k] = irq[k];
            m_state = nx;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge tck) begin
        logic e_tdo;
        e_tdo = 1'b0;
        if (m_state == SHIR) e_tdo = irq[0];
        else if (m_state == SHDR) e_tdo = drq[0];
        chk("tlr",        tlr,        m_state == TLR);
        chk("capture_dr", capture_dr, m_state == CDR);
        chk("shift_dr",   shift_dr,   m_state == SHDR);
        chk("update_dr",  update_dr,  m_state == UDR);
        chk("pin_tdo_oe", pin_tdo_oe, (m_state == SHDR) || (m_state == SHIR));
        chk("pin_tdo",    pin_tdo,    e_tdo);
        chk("ir",         ir,         m_ir);
        chk("user_sel",   user_sel,   m_is_user(m_ir));
        chk("tdi",        tdi,        pin_tdi);
        if (shift_dr && user_sel) chk("tdo_follow", pin_tdo, tdo);
    end

    int cap_cnt = 0, sh_cnt = 0, upd_cnt = 0;
    always @(negedge tck) begin
        if (capture_dr) cap_cnt++;
        if (shift_dr)   sh_cnt++;
        if (update_dr)  upd_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit t, input bit d, output bit o);
        o       = pin_tdo;
        tms     = t;
        pin_tdi = d;
        @(posedge tck);
        #2;
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [3:0] outb);
        bit o;
        step(1, 0, o); step(1, 0, o); step(0, 0, o); step(0, 0, o);
        for (int k = 0; k < 4; k++) begin
            step(k == 3, v[k], o);
            outb[k] = o;
        end
        step(1, 0, o);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, input int pause_at, output logic [31:0] dout);
        bit o;
        dout = '0;
        step(1, 0, o); step(0, 0, o); step(0, 0, o);
        for (int k = 0; k < n; k++) begin
            step((k == n - 1) || (k == pause_at - 1), din[k], o);
            dout[k] = o;
            if (k == pause_at - 1 && k != n - 1) begin
                step(0, 0, o); step(0, 0, o); step(1, 0, o); step(0, 0, o);
            end
        end
        step(1, 0, o);
        step(0, 0, o);
    endtask

    string paths [16] = '{"111", "", "1", "10", "100", "101", "1010", "10101", "1011",
                          "11", "110", "1100", "1101", "11010", "110101", "11011"};

    initial begin
        bit          o;
        logic [3:0]  ob;
        logic [31:0] dout;

        trst_n = 1'b0; tms = 1'b1; pin_tdi = 1'b0;
        repeat (2) @(posedge tck);
        #2;
        chk("rst_tlr",      tlr,        1'b1);
        chk("rst_oe",       pin_tdo_oe, 1'b0);
        chk("rst_tdo",      pin_tdo,    1'b0);
        chk("rst_ir",       ir,         C_RST);
        chk("rst_user_sel", user_sel,   1'b0);
        trst_n = 1'b1;
        step(0, 0, o);

`ifdef JTAG_TAP_IDCODE_EN
        dr_scan(32, 32'h0, 0, dout);
        chk("idcode_out", dout, 32'h1000_0001);
`endif

        ir_scan(4'h5, ob);
        chk("ir_scan_tdo",  ob,       4'b0001);
        chk("ir_upd",       ir,       4'h5);
        chk("ir5_user_sel", user_sel, 1'b1);
        step(0, 0, o);

        ir_scan(4'hF, ob);
        chk("irF_val",      ir,       4'hF);
        chk("irF_user_sel", user_sel, 1'b0);
        step(0, 0, o);
        dr_scan(8, 32'hCD, 0, dout);
        chk("bypass_out", dout[7:0], 8'h9A);

        ir_scan(4'h2, ob);
        step(0, 0, o);
        cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
        dr_scan(12, 32'h3B7, 5, dout);
        chk("user_out1", dout[11:0], 12'hA5C);
        chk("cap_cnt",   cap_cnt,    1);
        chk("sh_cnt",    sh_cnt,     12);
        chk("upd_cnt",   upd_cnt,    1);
        dr_scan(12, 32'h0F0, 0, dout);
        chk("user_out2", dout[11:0], 12'h3B7);

        ir_scan(4'h1, ob);
        chk("ir1_user_sel", user_sel, !IDC_EN);
        step(0, 0, o);
        dr_scan(12, 32'h0, 0, dout);
`ifdef JTAG_TAP_IDCODE_EN
        chk("ir1_out", dout[11:0], 12'h001);
`else
        chk("ir1_out", dout[11:0], 12'h0F0);
`endif

        // asynchronous reset in the middle of a bypass shift
        ir_scan(4'hF, ob);
        step(0, 0, o);
        step(1, 0, o); step(0, 0, o); step(0, 0, o); step(0, 1, o);
        chk("mid_oe_before", pin_tdo_oe, 1'b1);
        #1 trst_n = 1'b0;
        #1;
        chk("mid_tlr",   tlr,        1'b1);
        chk("mid_oe",    pin_tdo_oe, 1'b0);
        chk("mid_tdo",   pin_tdo,    1'b0);
        chk("mid_shift", shift_dr,   1'b0);
        chk("mid_ir",    ir,         C_RST);
        #3 trst_n = 1'b1;
        step(0, 0, o);

        for (int i = 0; i < 16; i++) begin
            ir_scan(4'h5, ob);
            step(0, 0, o);
            for (int k = 0; k < paths[i].len(); k++) step(paths[i][k] == "1", 0, o);
            chk("at_tlr", tlr, i == 0);
            repeat (5) step(1, 0, o);
            chk("tms5_tlr", tlr, 1'b1);
            chk("tms5_ir",  ir,  C_RST);
            step(0, 0, o);
        end

        repeat (2) @(posedge tck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
